sram_bus_arbiter: RTL and testbench

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

---
 rtl/sram_bus_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/sram_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// rtl/sram_bus_pkg.sv - shared defaults and FSM encodings for the SRAM bus arbiter
package sram_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int TYPE_W_DEF = 4;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_REQ  = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_REQ  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot arbiter, round-robin from pointer+1 or fixed lowest-index
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] pointer,
    input  logic          mode,
    output logic [N-1:0]  grant
);

    // Walk candidates from lowest to highest priority so the last hit wins.
    always_comb begin
        int cand;
        grant = '0;
        cand  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = mode ? ((int'(pointer) + 1 + k) % N) : k;
            if ((req & (N'(1) << cand)) != '0) begin
                grant = N'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - N-master to one SRAM slave arbiter with independent read and write channels
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int N_MST  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = 128,
    parameter int TYPE_W = TYPE_W_DEF,
    parameter int RR_EN  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_MST-1:0]           m_r_req,
    input  logic [N_MST*ADDR_W-1:0]    m_r_addr,
    input  logic [N_MST*TYPE_W-1:0]    m_r_type,
    output logic [N_MST-1:0]           m_r_rdy,
    output logic [DATA_W-1:0]          m_re_data,
    output logic [N_MST-1:0]           m_re_valid,
    input  logic [N_MST-1:0]           m_w_req,
    input  logic [N_MST*ADDR_W-1:0]    m_w_addr,
    input  logic [N_MST*TYPE_W-1:0]    m_w_type,
    input  logic [N_MST*DATA_W-1:0]    m_w_data,
    input  logic [N_MST*DATA_W/8-1:0]  m_w_strb,
    output logic [N_MST-1:0]           m_w_rdy,
    output logic                       s_r_req,
    output logic [ADDR_W-1:0]          s_r_addr,
    output logic [TYPE_W-1:0]          s_r_type,
    input  logic                       s_r_rdy,
    input  logic [DATA_W-1:0]          s_re_data,
    input  logic                       s_re_valid,
    output logic                       s_w_req,
    output logic [ADDR_W-1:0]          s_w_addr,
    output logic [TYPE_W-1:0]          s_w_type,
    output logic [DATA_W-1:0]          s_w_data,
    output logic [DATA_W/8-1:0]        s_w_strb,
    input  logic                       s_w_rdy
);

    localparam int   PW   = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int   SW   = DATA_W / 8;
    localparam logic MODE = (RR_EN != 0);

    logic [1:0]       r_state;
    logic [0:0]       w_state;
    logic [N_MST-1:0] r_gnt, w_gnt, r_arb_gnt, w_arb_gnt;
    logic [PW-1:0]    r_ptr, w_ptr, r_arb_idx, w_arb_idx;
    logic             r_sel_req, w_sel_req, r_in_req, r_in_resp, w_in_req;

    logic [ADDR_W-1:0] r_addr_mux, w_addr_mux;
    logic [TYPE_W-1:0] r_type_mux, w_type_mux;
    logic [DATA_W-1:0] w_data_mux;
    logic [SW-1:0]     w_strb_mux;

    rr_arbiter #(.N(N_MST), .PW(PW)) u_r_arb (
        .req(m_r_req), .pointer(r_ptr), .mode(MODE), .grant(r_arb_gnt)
    );

    rr_arbiter #(.N(N_MST), .PW(PW)) u_w_arb (
        .req(m_w_req), .pointer(w_ptr), .mode(MODE), .grant(w_arb_gnt)
    );

    always_comb begin
        r_arb_idx = '0;
        w_arb_idx = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (r_arb_gnt[i]) r_arb_idx = PW'(i);
            if (w_arb_gnt[i]) w_arb_idx = PW'(i);
        end
    end

    assign r_sel_req = |(m_r_req & r_gnt);
    assign w_sel_req = |(m_w_req & w_gnt);
    assign r_in_req  = (r_state == R_REQ);
    assign r_in_resp = (r_state == R_RESP);
    assign w_in_req  = (w_state == W_REQ);

    // A master withdrawing its request in R_REQ aborts before any slave handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_gnt   <= '0;
            r_ptr   <= PW'(N_MST - 1);
        end else begin
            case (r_state)
                R_IDLE: if (|m_r_req) begin
                    r_gnt   <= r_arb_gnt;
                    r_ptr   <= r_arb_idx;
                    r_state <= R_REQ;
                end
                R_REQ: begin
                    if (!r_sel_req)   r_state <= R_IDLE;
                    else if (s_r_rdy) r_state <= R_RESP;
                end
                R_RESP:  if (s_re_valid) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_gnt   <= '0;
            w_ptr   <= PW'(N_MST - 1);
        end else begin
            case (w_state)
                W_IDLE: if (|m_w_req) begin
                    w_gnt   <= w_arb_gnt;
                    w_ptr   <= w_arb_idx;
                    w_state <= W_REQ;
                end
                default: if (!w_sel_req || s_w_rdy) w_state <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        r_addr_mux = '0;
        r_type_mux = '0;
        w_addr_mux = '0;
        w_type_mux = '0;
        w_data_mux = '0;
        w_strb_mux = '0;
        for (int i = 0; i < N_MST; i++) begin
            r_addr_mux |= m_r_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{r_gnt[i]}};
            r_type_mux |= m_r_type[i*TYPE_W +: TYPE_W] & {TYPE_W{r_gnt[i]}};
            w_addr_mux |= m_w_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{w_gnt[i]}};
            w_type_mux |= m_w_type[i*TYPE_W +: TYPE_W] & {TYPE_W{w_gnt[i]}};
            w_data_mux |= m_w_data[i*DATA_W +: DATA_W] & {DATA_W{w_gnt[i]}};
            w_strb_mux |= m_w_strb[i*SW +: SW]         & {SW{w_gnt[i]}};
        end
    end

    // Every master-facing and slave-facing output is qualified by state, so idle and reset drive zeros.
    assign s_r_req    = r_in_req & r_sel_req;
    assign s_r_addr   = r_in_req ? r_addr_mux : '0;
    assign s_r_type   = r_in_req ? r_type_mux : '0;
    assign m_r_rdy    = r_gnt & {N_MST{r_in_req & s_r_rdy}};
    assign m_re_valid = r_gnt & {N_MST{r_in_resp & s_re_valid}};
    assign m_re_data  = r_in_resp ? s_re_data : '0;

    assign s_w_req    = w_in_req & w_sel_req;
    assign s_w_addr   = w_in_req ? w_addr_mux : '0;
    assign s_w_type   = w_in_req ? w_type_mux : '0;
    assign s_w_data   = w_in_req ? w_data_mux : '0;
    assign s_w_strb   = w_in_req ? w_strb_mux : '0;
    assign m_w_rdy    = w_gnt & {N_MST{w_in_req & s_w_rdy}};

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed scoreboard bench for sram_bus_arbiter (round-robin and fixed-priority instances)
module tb_sram_bus_arbiter;

    localparam int N = 4;
    localparam int A = 32;
    localparam int D = 128;
    localparam int T = 4;
    localparam int S = D / 8;

    typedef struct packed {
        logic [N-1:0] v;
        logic [D-1:0] d;
    } rd_exp_t;

    typedef struct packed {
        logic [A-1:0] addr;
        logic [T-1:0] typ;
        logic [D-1:0] data;
        logic [S-1:0] strb;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]   m_r_req, m_w_req;
    logic [N*A-1:0] m_r_addr, m_w_addr;
    logic [N*T-1:0] m_r_type, m_w_type;
    logic [N*D-1:0] m_w_data;
    logic [N*S-1:0] m_w_strb;
    logic           s_r_rdy, s_re_valid, s_w_rdy;
    logic [D-1:0]   s_re_data;

    logic [N-1:0] m_r_rdy_rr, m_re_valid_rr, m_w_rdy_rr, m_r_rdy_fp, m_re_valid_fp, m_w_rdy_fp;
    logic [D-1:0] m_re_data_rr, m_re_data_fp, s_w_data_rr, s_w_data_fp;
    logic         s_r_req_rr, s_w_req_rr, s_r_req_fp, s_w_req_fp;
    logic [A-1:0] s_r_addr_rr, s_w_addr_rr, s_r_addr_fp, s_w_addr_fp;
    logic [T-1:0] s_r_type_rr, s_w_type_rr, s_r_type_fp, s_w_type_fp;
    logic [S-1:0] s_w_strb_rr, s_w_strb_fp;

    rd_exp_t rq_rr[$];
    rd_exp_t rq_fp[$];
    wr_exp_t wq[$];
    int n_checks = 0;
    int n_fail   = 0;
    int tag_k    = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.N_MST(N), .ADDR_W(A), .DATA_W(D), .TYPE_W(T), .RR_EN(1)) dut_rr (
        .clk(clk), .rst(rst),
        .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(m_r_rdy_rr),
        .m_re_data(m_re_data_rr), .m_re_valid(m_re_valid_rr),
        .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_type(m_w_type), .m_w_data(m_w_data),
        .m_w_strb(m_w_strb), .m_w_rdy(m_w_rdy_rr),
        .s_r_req(s_r_req_rr), .s_r_addr(s_r_addr_rr), .s_r_type(s_r_type_rr), .s_r_rdy(s_r_rdy),
        .s_re_data(s_re_data), .s_re_valid(s_re_valid),
        .s_w_req(s_w_req_rr), .s_w_addr(s_w_addr_rr), .s_w_type(s_w_type_rr),
        .s_w_data(s_w_data_rr), .s_w_strb(s_w_strb_rr), .s_w_rdy(s_w_rdy)
    );

    sram_bus_arbiter #(.N_MST(N), .ADDR_W(A), .DATA_W(D), .TYPE_W(T), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(m_r_rdy_fp),
        .m_re_data(m_re_data_fp), .m_re_valid(m_re_valid_fp),
        .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_type(m_w_type), .m_w_data(m_w_data),
        .m_w_strb(m_w_strb), .m_w_rdy(m_w_rdy_fp),
        .s_r_req(s_r_req_fp), .s_r_addr(s_r_addr_fp), .s_r_type(s_r_type_fp), .s_r_rdy(s_r_rdy),
        .s_re_data(s_re_data), .s_re_valid(s_re_valid),
        .s_w_req(s_w_req_fp), .s_w_addr(s_w_addr_fp), .s_w_type(s_w_type_fp),
        .s_w_data(s_w_data_fp), .s_w_strb(s_w_strb_fp), .s_w_rdy(s_w_rdy)
    );

    task automatic chk(input string name, input logic [D-1:0] obs, input logic [D-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [A-1:0] raddr(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h10;
    endfunction

    function automatic logic [D-1:0] mk_tag(input int k);
        return {4{32'hD000_0000 + 32'(k)}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read data scoreboard: every m_re_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        rd_exp_t e;
        if (m_re_valid_rr !== '0) begin
            chk("rd_rr_pending", D'(rq_rr.size() > 0), D'(1));
            if (rq_rr.size() > 0) begin
                e = rq_rr.pop_front();
                chk("rd_rr_owner", D'(m_re_valid_rr), D'(e.v));
                chk("rd_rr_data", m_re_data_rr, e.d);
            end
        end
        if (m_re_valid_fp !== '0) begin
            chk("rd_fp_pending", D'(rq_fp.size() > 0), D'(1));
            if (rq_fp.size() > 0) begin
                e = rq_fp.pop_front();
                chk("rd_fp_owner", D'(m_re_valid_fp), D'(e.v));
                chk("rd_fp_data", m_re_data_fp, e.d);
            end
        end
    end

    always @(negedge clk) begin
        wr_exp_t w;
        if (s_w_req_rr === 1'b1 && s_w_rdy === 1'b1) begin
            chk("wr_pending", D'(wq.size() > 0), D'(1));
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("wr_addr", D'(s_w_addr_rr), D'(w.addr));
                chk("wr_type", D'(s_w_type_rr), D'(w.typ));
                chk("wr_data", s_w_data_rr, w.data);
                chk("wr_strb", D'(s_w_strb_rr), D'(w.strb));
            end
        end
    end

    // Entered at posedge+1 with both read FSMs idle and requests already driven.
    task automatic rd_txn(input int prr, input int pfp);
        rd_exp_t e;
        logic [D-1:0] tag;
        tag = mk_tag(tag_k);
        tag_k++;
        @(negedge clk);
        chk("idle_sreq", D'(s_r_req_rr), D'(0));
        chk("idle_rdy", D'(m_r_rdy_rr), D'(0));
        tick();
        s_r_rdy = 1'b1;
        e.v = N'(1 << prr); e.d = tag; rq_rr.push_back(e);
        e.v = N'(1 << pfp); rq_fp.push_back(e);
        @(negedge clk);
        chk("req_sreq", D'(s_r_req_rr), D'(1));
        chk("gnt_rr", D'(m_r_rdy_rr), D'(1 << prr));
        chk("addr_rr", D'(s_r_addr_rr), D'(raddr(prr)));
        chk("type_rr", D'(s_r_type_rr), D'(prr));
        chk("gnt_fp", D'(m_r_rdy_fp), D'(1 << pfp));
        chk("addr_fp", D'(s_r_addr_fp), D'(raddr(pfp)));
        tick();
        s_r_rdy = 1'b0;
        @(negedge clk);
        chk("resp_wait_valid", D'(m_re_valid_rr), D'(0));
        chk("resp_wait_sreq", D'(s_r_req_rr), D'(0));
        tick();
        s_re_valid = 1'b1;
        s_re_data  = tag;
        @(negedge clk);
        tick();
        s_re_valid = 1'b0;
        s_re_data  = '0;
    endtask

    initial begin
        wr_exp_t w;
        rst = 1'b1;
        m_r_req = '1; m_w_req = '1;
        s_r_rdy = 1'b1; s_w_rdy = 1'b1; s_re_valid = 1'b1; s_re_data = '1;
        for (int i = 0; i < N; i++) begin
            m_r_addr[i*A +: A] = raddr(i);
            m_r_type[i*T +: T] = T'(i);
            m_w_addr[i*A +: A] = 32'h8000_0020 + 32'(i) * 32'h20;
            m_w_type[i*T +: T] = T'(i + 8);
            m_w_data[i*D +: D] = {4{32'hA000_0000 + 32'(i)}};
            m_w_strb[i*S +: S] = 16'hFFFF >> i;
        end

        // Reset: everything quiet despite active requests and slave strobes.
        @(negedge clk);
        chk("rst_rd_rr", D'({s_r_req_rr, m_r_rdy_rr, m_re_valid_rr, s_r_type_rr, s_r_addr_rr}), D'(0));
        chk("rst_rdata_rr", m_re_data_rr, D'(0));
        chk("rst_wr_rr", D'({s_w_req_rr, m_w_rdy_rr, s_w_type_rr, s_w_addr_rr, s_w_strb_rr}), D'(0));
        chk("rst_wdata_rr", s_w_data_rr, D'(0));
        chk("rst_rd_fp", D'({s_r_req_fp, m_r_rdy_fp, m_re_valid_fp, s_r_type_fp, s_r_addr_fp}), D'(0));
        chk("rst_w_fp", D'({s_w_req_fp, m_w_rdy_fp, s_w_type_fp, s_w_addr_fp, s_w_strb_fp}), D'(0));
        chk("rst_data_fp", m_re_data_fp | s_w_data_fp, D'(0));
        tick();
        rst = 1'b0;
        m_w_req = '0; s_r_rdy = 1'b0; s_w_rdy = 1'b0; s_re_valid = 1'b0; s_re_data = '0;

        // All four masters reading continuously.
        m_r_req = 4'b1111;
        rd_txn(0, 0);
        rd_txn(1, 0);
        rd_txn(2, 0);
        rd_txn(3, 0);
        rd_txn(0, 0);

        // Masters 1 and 3 only; fixed priority keeps serving 1.
        m_r_req = 4'b1010;
        rd_txn(1, 1);
        rd_txn(3, 1);
        rd_txn(1, 1);
        m_r_req = 4'b1000;
        rd_txn(3, 3);

        // Concurrent read (master 2) and write (master 0).
        m_r_req = 4'b0100;
        m_r_addr[2*A +: A] = 32'h8000_0010;
        m_w_req = 4'b0001;
        @(negedge clk);
        chk("w_idle_sreq", D'(s_w_req_rr), D'(0));
        chk("w_idle_rdy", D'(m_w_rdy_rr), D'(0));
        tick();
        s_r_rdy = 1'b1; s_w_rdy = 1'b1;
        begin
            rd_exp_t e;
            e.v = 4'b0100; e.d = mk_tag(100);
            rq_rr.push_back(e); rq_fp.push_back(e);
        end
        w.addr = 32'h8000_0020; w.typ = 4'd8; w.data = {4{32'hA000_0000}}; w.strb = 16'hFFFF;
        wq.push_back(w);
        @(negedge clk);
        chk("cc_sreq", D'({s_r_req_rr, s_w_req_rr}), D'(2'b11));
        chk("cc_raddr", D'(s_r_addr_rr), D'(32'h8000_0010));
        chk("cc_rrdy", D'(m_r_rdy_rr), D'(4'b0100));
        chk("cc_wrdy", D'(m_w_rdy_rr), D'(4'b0001));
        tick();
        s_r_rdy = 1'b0; s_w_rdy = 1'b0; m_r_req = '0; m_w_req = '0;
        m_r_addr[2*A +: A] = raddr(2);
        @(negedge clk);
        chk("cc_w_done", D'({s_w_req_rr, m_w_rdy_rr}), D'(0));
        tick();
        s_re_valid = 1'b1; s_re_data = mk_tag(100);
        @(negedge clk);
        tick();
        s_re_valid = 1'b0; s_re_data = '0;

        // Two writers: round-robin moves past master 0, fixed priority does not.
        m_w_req = 4'b0011;
        @(negedge clk);
        tick();
        s_w_rdy = 1'b1;
        w.addr = 32'h8000_0040; w.typ = 4'd9; w.data = {4{32'hA000_0001}}; w.strb = 16'h7FFF;
        wq.push_back(w);
        @(negedge clk);
        chk("w2_rdy_rr", D'(m_w_rdy_rr), D'(4'b0010));
        chk("w2_rdy_fp", D'(m_w_rdy_fp), D'(4'b0001));
        chk("w2_addr_fp", D'(s_w_addr_fp), D'(32'h8000_0020));
        tick();
        s_w_rdy = 1'b0; m_w_req = '0;

        // Master 1 withdraws its read before the slave accepts.
        m_r_req = 4'b0010;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("wd_sreq_on", D'(s_r_req_rr), D'(1));
        chk("wd_addr", D'(s_r_addr_rr), D'(raddr(1)));
        tick();
        m_r_req = '0;
        @(negedge clk);
        chk("wd_sreq_off", D'(s_r_req_rr), D'(0));
        tick();
        s_re_valid = 1'b1; s_re_data = '1;
        @(negedge clk);
        chk("wd_stray_valid", D'({m_re_valid_rr, m_re_valid_fp}), D'(0));
        chk("wd_sreq_idle", D'(s_r_req_rr), D'(0));
        tick();
        s_re_valid = 1'b0; s_re_data = '0;

        // Reset while waiting for read data; the late response must vanish.
        m_r_req = 4'b1000;
        @(negedge clk);
        tick();
        s_r_rdy = 1'b1;
        @(negedge clk);
        chk("rr_rdy3", D'(m_r_rdy_rr), D'(4'b1000));
        tick();
        s_r_rdy = 1'b0; m_r_req = '0;
        @(negedge clk);
        chk("rr_wait", D'(m_re_valid_rr), D'(0));
        tick();
        rst = 1'b1; s_re_valid = 1'b1; s_re_data = mk_tag(200);
        @(negedge clk);
        chk("mid_rst_rd", D'({s_r_req_rr, m_r_rdy_rr, m_re_valid_rr, m_re_valid_fp}), D'(0));
        chk("mid_rst_data", m_re_data_rr, D'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", D'({m_re_valid_rr, m_re_valid_fp}), D'(0));
        tick();
        s_re_valid = 1'b0; s_re_data = '0;
        m_r_req = 4'b1111;
        rd_txn(0, 0);
        m_r_req = '0;

        @(negedge clk);
        chk("rq_rr_empty", D'(rq_rr.size()), D'(0));
        chk("rq_fp_empty", D'(rq_fp.size()), D'(0));
        chk("wq_empty", D'(wq.size()), D'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
